stg_xt_useq: RTL

//  Translate stage, second generation: expands ISA macro ops into micro-op sequences.

---
 rtl/stg_xt_useq_pkg.sv | 78 +++++++
 rtl/stg_xt_useq_if.sv | 39 +++
 rtl/xt_uop_rom.sv | 103 ++++++++++
 rtl/stg_xt_useq.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/stg_xt_useq_pkg.sv
// Translate stage shared definitions: opcodes, SR indices,
// sequence lengths, FSM states and micro-op pack helpers.
package stg_xt_useq_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } xt_state_e;

  localparam int SEQ_LEN_JSR = 4;
  localparam int SEQ_LEN_RET = 3;

  localparam logic [1:0] SR_IDX_PC  = 2'd0;
  localparam logic [1:0] SR_IDX_LR  = 2'd1;
  localparam logic [1:0] SR_IDX_SSP = 2'd2;

  localparam logic [3:0] CC0 = 4'h0;

  localparam logic [7:0] OPC_SRMOVAur = 8'h70;
  localparam logic [7:0] OPC_SRMOVur  = 8'h71;
  localparam logic [7:0] OPC_SRSUBsi  = 8'h72;
  localparam logic [7:0] OPC_SRADDsi  = 8'h73;
  localparam logic [7:0] OPC_SRSTso   = 8'h74;
  localparam logic [7:0] OPC_SRLDso   = 8'h75;
  localparam logic [7:0] OPC_SRJCCso  = 8'h76;
  localparam logic [7:0] OPC_JCCui    = 8'h80;
  localparam logic [7:0] OPC_BCCsr    = 8'h81;
  localparam logic [7:0] OPC_BCCso    = 8'h82;
  localparam logic [7:0] OPC_BALso    = 8'h83;
  localparam logic [7:0] OPC_JSRui    = 8'h60;
  localparam logic [7:0] OPC_BSRsr    = 8'h61;
  localparam logic [7:0] OPC_BSRso    = 8'h62;
  localparam logic [7:0] OPC_RET      = 8'h63;
  localparam logic [7:0] OPC_BTP      = 8'h64;
  localparam logic [7:0] OPC_SETSSP   = 8'h65;

  function automatic logic [23:0] pack_sr_imm14(
    logic [7:0] opc, logic [1:0] sr, logic [13:0] imm);
    return {opc, sr, imm};
  endfunction

  function automatic logic [23:0] pack_sr_sr_imm12(
    logic [7:0] opc, logic [1:0] sa, logic [1:0] sb,
    logic [11:0] imm);
    return {opc, sa, sb, imm};
  endfunction

  function automatic logic [23:0] pack_sr_sr(
    logic [7:0] opc, logic [1:0] sa, logic [1:0] sb);
    return {opc, sa, sb, 12'h000};
  endfunction

  function automatic logic [23:0] pack_sr_cc_imm10(
    logic [7:0] opc, logic [1:0] sr, logic [3:0] cc,
    logic [9:0] imm);
    return {opc, sr, cc, imm};
  endfunction

  function automatic logic [23:0] pack_jccui(
    logic [7:0] opc, logic [3:0] cc, logic [11:0] imm);
    return {opc, cc, imm};
  endfunction

  function automatic logic [23:0] pack_bccsr(
    logic [7:0] opc, logic [3:0] rs, logic [3:0] cc);
    return {opc, rs, cc, 8'h00};
  endfunction

  function automatic logic [23:0] pack_balso(
    logic [7:0] opc, logic [15:0] off);
    return {opc, off};
  endfunction

  function automatic logic [23:0] pack_nop();
    return 24'h000000;
  endfunction

endpackage

// File: rtl/stg_xt_useq_if.sv
// Fetch-to-translate and translate-to-decode bundle.
// master drives iw_*, slave (the translate stage) drives ow_*.
interface stg_xt_useq_if #(
  parameter int P_DATA_W  = 24,
  parameter int P_ADDR_W  = 24,
  parameter int P_MAX_SEQ = 4
);
  localparam int IW = $clog2(P_MAX_SEQ);

  logic [P_ADDR_W-1:0] iw_pc;
  logic [P_DATA_W-1:0] iw_instr;
  logic                iw_valid;
  logic                iw_flush;
  logic                iw_stall;
  logic [P_ADDR_W-1:0] ow_pc;
  logic [P_DATA_W-1:0] ow_instr;
  logic                ow_valid;
  logic                ow_first;
  logic                ow_last;
  logic [IW-1:0]       ow_idx;
  logic                ow_illegal;
  logic                ow_hold;

  modport master (
    output iw_pc, iw_instr, iw_valid,
    output iw_flush, iw_stall,
    input  ow_pc, ow_instr, ow_valid,
    input  ow_first, ow_last, ow_idx,
    input  ow_illegal, ow_hold
  );

  modport slave (
    input  iw_pc, iw_instr, iw_valid,
    input  iw_flush, iw_stall,
    output ow_pc, ow_instr, ow_valid,
    output ow_first, ow_last, ow_idx,
    output ow_illegal, ow_hold
  );
endinterface

// File: rtl/xt_uop_rom.sv
// Macro-op expansion table: instruction to micro-op list.
// Single ops land in list[0]; unknown ops become NOP + illegal.
module xt_uop_rom
  import stg_xt_useq_pkg::*;
#(
  parameter int P_DATA_W   = 24,
  parameter int P_MAX_SEQ  = 4,
  parameter int P_SSP_STEP = 2,
  localparam int CW = $clog2(P_MAX_SEQ + 1)
) (
  input  logic [P_DATA_W-1:0]                instr,
  output logic                               is_seq,
  output logic [CW-1:0]                      len,
  output logic                               illegal,
  output logic [P_MAX_SEQ-1:0][P_DATA_W-1:0] list
);
  localparam logic [13:0] S14  = 14'(P_SSP_STEP);
  localparam logic [11:0] NS12 = 12'(-P_SSP_STEP);

  logic [7:0]  opc;
  logic [3:0]  cls;
  logic [3:0]  sub;
  logic        pass;
  logic [23:0] pro0;
  logic [23:0] pro1;
  logic [23:0] pro2;

  assign opc  = instr[23:16];
  assign cls  = opc[7:4];
  assign sub  = opc[3:0];
  assign pass = (cls <= 4'h5) | (cls == 4'h7)
              | (cls == 4'hF)
              | ((cls == 4'h8) & (sub <= 4'h3));

  assign pro0 = pack_sr_imm14(OPC_SRSUBsi,
                  SR_IDX_SSP, S14);
  assign pro1 = pack_sr_sr_imm12(OPC_SRSTso,
                  SR_IDX_SSP, SR_IDX_LR, 12'h000);
  assign pro2 = pack_sr_sr(OPC_SRMOVur,
                  SR_IDX_LR, SR_IDX_PC);

  // Decode opclass/subop into a micro-op list
  always_comb begin
    is_seq  = 1'b0;
    len     = '0;
    illegal = 1'b0;
    list    = '0;
    list[0] = instr;
    unique case (1'b1)
      pass: ;
      (opc == OPC_JSRui): begin
        is_seq  = 1'b1;
        len     = CW'(SEQ_LEN_JSR);
        list[0] = P_DATA_W'(pro0);
        list[1] = P_DATA_W'(pro1);
        list[2] = P_DATA_W'(pro2);
        list[3] = P_DATA_W'(pack_jccui(
                    OPC_JCCui, CC0, instr[11:0]));
      end
      (opc == OPC_BSRsr): begin
        is_seq  = 1'b1;
        len     = CW'(SEQ_LEN_JSR);
        list[0] = P_DATA_W'(pro0);
        list[1] = P_DATA_W'(pro1);
        list[2] = P_DATA_W'(pro2);
        list[3] = P_DATA_W'(pack_bccsr(
                    OPC_BCCsr, instr[15:12], CC0));
      end
      (opc == OPC_BSRso): begin
        is_seq  = 1'b1;
        len     = CW'(SEQ_LEN_JSR);
        list[0] = P_DATA_W'(pro0);
        list[1] = P_DATA_W'(pro1);
        list[2] = P_DATA_W'(pro2);
        list[3] = P_DATA_W'(pack_balso(
                    OPC_BALso, instr[15:0]));
      end
      (opc == OPC_RET): begin
        is_seq  = 1'b1;
        len     = CW'(SEQ_LEN_RET);
        list[0] = P_DATA_W'(pack_sr_imm14(
                    OPC_SRADDsi, SR_IDX_SSP, S14));
        list[1] = P_DATA_W'(pack_sr_sr_imm12(
                    OPC_SRLDso, SR_IDX_LR,
                    SR_IDX_SSP, NS12));
        list[2] = P_DATA_W'(pack_sr_cc_imm10(
                    OPC_SRJCCso, SR_IDX_LR,
                    CC0, 10'd1));
      end
      (opc == OPC_BTP): begin
        list[0] = P_DATA_W'(pack_nop());
      end
      (opc == OPC_SETSSP): begin
        list[0] = P_DATA_W'({OPC_SRMOVAur,
                    SR_IDX_SSP, instr[15:14], 12'h000});
      end
      default: begin
        illegal = 1'b1;
        list[0] = P_DATA_W'(pack_nop());
      end
    endcase
  end
endmodule

// File: rtl/stg_xt_useq.sv
// Translate stage: expands macro ops into micro-op sequences,
// holding fetch until the last micro-op is issued.
module stg_xt_useq
  import stg_xt_useq_pkg::*;
#(
  parameter int P_DATA_W   = 24,
  parameter int P_ADDR_W   = 24,
  parameter int P_MAX_SEQ  = 4,
  parameter int P_SSP_STEP = 2
) (
  input  logic         iw_clk,
  input  logic         iw_rst,
  stg_xt_useq_if.slave bus
);
  localparam int CW = $clog2(P_MAX_SEQ + 1);
  localparam int IW = $clog2(P_MAX_SEQ);

  typedef logic [P_MAX_SEQ-1:0][P_DATA_W-1:0] list_t;

  xt_state_e           state_q, state_d;
  logic [CW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  list_t               buf_q, buf_d;
  logic [P_ADDR_W-1:0] pc_hold_q, pc_hold_d;
  logic [P_ADDR_W-1:0] out_pc_q, out_pc_d;
  logic [P_DATA_W-1:0] out_instr_q, out_instr_d;
  logic                out_valid_q, out_valid_d;
  logic                out_first_q, out_first_d;
  logic                out_last_q, out_last_d;
  logic [IW-1:0]       out_idx_q, out_idx_d;
  logic                out_ill_q, out_ill_d;

  logic                rom_is_seq;
  logic [CW-1:0]       rom_len;
  logic                rom_ill;
  list_t               rom_list;
  logic                seq_start;
  logic                more;

  xt_uop_rom #(
    .P_DATA_W  (P_DATA_W),
    .P_MAX_SEQ (P_MAX_SEQ),
    .P_SSP_STEP(P_SSP_STEP)
  ) u_rom (
    .instr  (bus.iw_instr),
    .is_seq (rom_is_seq),
    .len    (rom_len),
    .illegal(rom_ill),
    .list   (rom_list)
  );

  assign seq_start = (state_q == ST_IDLE)
                   & bus.iw_valid & rom_is_seq;
  assign more      = (state_q == ST_BUSY)
                   & ((idx_q + CW'(1)) < cnt_q);
  assign bus.ow_hold = ~bus.iw_flush
                     & (seq_start | more);

  assign bus.ow_pc      = out_pc_q;
  assign bus.ow_instr   = out_instr_q;
  assign bus.ow_valid   = out_valid_q;
  assign bus.ow_first   = out_first_q;
  assign bus.ow_last    = out_last_q;
  assign bus.ow_idx     = out_idx_q;
  assign bus.ow_illegal = out_ill_q;

  // Next state, buffer load and registered micro-op output
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    pc_hold_d   = pc_hold_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    out_valid_d = out_valid_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    out_idx_d   = out_idx_q;
    out_ill_d   = out_ill_q;
    if (bus.iw_flush) begin
      state_d     = ST_IDLE;
      idx_d       = '0;
      cnt_d       = '0;
      out_pc_d    = '0;
      out_instr_d = '0;
      out_valid_d = 1'b0;
      out_first_d = 1'b0;
      out_last_d  = 1'b0;
      out_idx_d   = '0;
      out_ill_d   = 1'b0;
    end else if (!bus.iw_stall) begin
      out_pc_d    = '0;
      out_instr_d = '0;
      out_valid_d = 1'b0;
      out_first_d = 1'b0;
      out_last_d  = 1'b0;
      out_idx_d   = '0;
      out_ill_d   = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.iw_valid) begin
            out_pc_d    = bus.iw_pc;
            out_instr_d = rom_list[0];
            out_valid_d = 1'b1;
            out_first_d = 1'b1;
            out_last_d  = ~rom_is_seq;
            out_ill_d   = rom_ill;
            if (rom_is_seq) begin
              buf_d     = rom_list;
              cnt_d     = rom_len;
              idx_d     = CW'(1);
              pc_hold_d = bus.iw_pc;
              state_d   = ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          out_pc_d    = pc_hold_q;
          out_instr_d = buf_q[idx_q[IW-1:0]];
          out_valid_d = 1'b1;
          out_idx_d   = idx_q[IW-1:0];
          if (idx_q == cnt_q - CW'(1)) begin
            out_last_d = 1'b1;
            idx_d      = '0;
            cnt_d      = '0;
            state_d    = ST_IDLE;
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end
      endcase
    end
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      buf_q       <= '0;
      pc_hold_q   <= '0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_idx_q   <= '0;
      out_ill_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      pc_hold_q   <= pc_hold_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      out_idx_q   <= out_idx_d;
      out_ill_q   <= out_ill_d;
    end
  end
endmodule
